ysyx_alu: RTL and testbench



---
 rtl/ysyx_alu.sv | 84 ++++++++
 tb/tb_ysyx_alu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_alu.sv
// Registered 32-bit integer ALU for the execute stage: one-cycle latency, result held while idle.
// Optional registered zero flag on res, enabled by defining YSYX_ALU_ZERO_FLAG_EN.
module ysyx_alu (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] var1,
  input  logic [31:0] var2,
  input  logic [2:0]  opt,
  input  logic        snpc,
  input  logic        ext,
  input  logic        sign,
  input  logic        negate,
  output logic [31:0] res,
`ifdef YSYX_ALU_ZERO_FLAG_EN
  output logic        zero,
`endif
  output logic        out_valid
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SLL = 3'b001,
    OP_LT  = 3'b010,
    OP_XOR = 3'b011,
    OP_SR  = 3'b100,
    OP_OR  = 3'b101,
    OP_AND = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_e;

  alu_op_e     op;
  logic [4:0]  shamt;
  logic [31:0] var1_l;
  logic [31:0] sum;
  logic [31:0] sra;
  logic        lt_bit;
  logic [31:0] result;

  assign op     = alu_op_e'(opt);
  assign shamt  = var2[4:0];
  // Logic ops share the optional inversion of var1 (CSRRC needs ~rs1 & csr).
  assign var1_l = negate ? ~var1 : var1;
  assign sum    = negate ? (var1 - var2) : (var1 + var2);
  assign sra    = $unsigned($signed(var1) >>> shamt);
  assign lt_bit = sign ? ($signed(var1) < $signed(var2)) : (var1 < var2);

  always_comb begin
    result = 32'd0;
    if (snpc) begin
      result = var1 + 32'd4;
    end else begin
      unique case (op)
        OP_ADD:  result = ext ? var1 : sum;
        OP_SLL:  result = var1 << shamt;
        OP_LT:   result = {31'd0, lt_bit ^ negate};
        OP_XOR:  result = var1_l ^ var2;
        OP_SR:   result = sign ? sra : (var1 >> shamt);
        OP_OR:   result = var1_l | var2;
        OP_AND:  result = var1_l & var2;
        OP_EQ:   result = {31'd0, (var1 == var2) ^ negate};
        default: result = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res       <= 32'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) res <= result;
    end
  end

`ifdef YSYX_ALU_ZERO_FLAG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         zero <= 1'b0;
    else if (in_valid) zero <= (result == 32'd0);
  end
`endif

endmodule

// File: tb/tb_ysyx_alu.sv
// Scoreboard bench for ysyx_alu: directed vectors push hand-computed results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_ysyx_alu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] var1 = '0;
  logic [31:0] var2 = '0;
  logic [2:0]  opt = '0;
  logic        snpc = 1'b0;
  logic        ext = 1'b0;
  logic        sign = 1'b0;
  logic        negate = 1'b0;
  logic [31:0] res;
  logic        out_valid;
`ifdef YSYX_ALU_ZERO_FLAG_EN
  logic        zero;
`endif

  ysyx_alu dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .var1(var1), .var2(var2), .opt(opt),
    .snpc(snpc), .ext(ext), .sign(sign), .negate(negate),
    .res(res),
`ifdef YSYX_ALU_ZERO_FLAG_EN
    .zero(zero),
`endif
    .out_valid(out_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] res;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clock) begin
    if (!reset && out_valid) begin
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: res=%08h with no pending operation", res);
      end else begin
        e = q.pop_front();
        if (res !== e.res) begin
          n_bad++;
          $display("FAIL %s: res got %08h expected %08h", e.name, res, e.res);
        end
`ifdef YSYX_ALU_ZERO_FLAG_EN
        n_cmp++;
        if (zero !== (e.res == 32'd0)) begin
          n_bad++;
          $display("FAIL %s_zero: zero got %0b expected %0b", e.name, zero, (e.res == 32'd0));
        end
`endif
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic sn, input logic ex,
                       input logic sg, input logic ng, input logic [31:0] expect_res);
    exp_t e;
    @(posedge clock);
    #1;
    in_valid = 1'b1;
    opt = o; var1 = a; var2 = b;
    snpc = sn; ext = ex; sign = sg; negate = ng;
    e.name = name;
    e.res  = expect_res;
    q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    var1 = $urandom; var2 = $urandom; opt = 3'($urandom);
    snpc = 1'b0; ext = 1'($urandom); sign = 1'($urandom); negate = 1'($urandom);
  endtask

  task automatic check(input string name, input logic [31:0] exp_res, input logic exp_ov);
    n_cmp++;
    if (res !== exp_res || out_valid !== exp_ov) begin
      n_bad++;
      $display("FAIL %s: res/out_valid got %08h/%0b expected %08h/%0b",
               name, res, out_valid, exp_res, exp_ov);
    end
  endtask

  // Checks the state after the next edge, which must be an in_valid=0 edge.
  task automatic check_hold(input string name, input logic [31:0] exp_res);
    @(posedge clock);
    #1;
    check(name, exp_res, 1'b0);
  endtask

  initial begin
    #2;
    check("reset_state", 32'd0, 1'b0);
`ifdef YSYX_ALU_ZERO_FLAG_EN
    n_cmp++;
    if (zero !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_zero: got %0b expected 0", zero);
    end
`endif
    @(negedge clock);
    reset = 1'b0;
    idle();
    check_hold("hold_after_reset", 32'd0);

    //    name         opt     var1          var2         sn ext sg ng  expected
    issue("add_wrap",  3'b000, 32'hFFFFFFFF, 32'h1,        0, 0, 0, 0, 32'h00000000);
    issue("sub",       3'b000, 32'd3,        32'd5,        0, 0, 0, 1, 32'hFFFFFFFE);
    issue("pass",      3'b000, 32'h1234,     32'hDEAD,     0, 1, 0, 1, 32'h00001234);
    issue("sll_mask",  3'b001, 32'd1,        32'h21,       0, 0, 0, 0, 32'h00000002);
    issue("sll_8",     3'b001, 32'hFF,       32'd8,        0, 0, 1, 1, 32'h0000FF00);
    issue("srl",       3'b100, 32'h80000000, 32'd4,        0, 0, 0, 0, 32'h08000000);
    issue("sra",       3'b100, 32'h80000000, 32'd4,        0, 0, 1, 0, 32'hF8000000);
    issue("lt_s",      3'b010, 32'hFFFFFFFF, 32'd1,        0, 0, 1, 0, 32'h00000001);
    issue("lt_u",      3'b010, 32'hFFFFFFFF, 32'd1,        0, 0, 0, 0, 32'h00000000);
    issue("ge_u",      3'b010, 32'hFFFFFFFF, 32'd1,        0, 0, 0, 1, 32'h00000001);
    issue("ne_equal",  3'b111, 32'd7,        32'd7,        0, 0, 0, 1, 32'h00000000);
    issue("eq_equal",  3'b111, 32'd7,        32'd7,        0, 0, 0, 0, 32'h00000001);
    issue("andn",      3'b110, 32'h0F,       32'hFF,       0, 0, 0, 1, 32'h000000F0);
    issue("or",        3'b101, 32'h100,      32'h1,        0, 0, 0, 0, 32'h00000101);
    issue("or_ext",    3'b101, 32'h10,       32'h1,        0, 1, 1, 0, 32'h00000011);
    issue("orn",       3'b101, 32'hFFFFFF00, 32'h0,        0, 0, 0, 1, 32'h000000FF);
    issue("xor_same",  3'b011, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 0, 32'h00000000);
    issue("xorn",      3'b011, 32'h0,        32'h0F0F0F0F, 0, 0, 0, 1, 32'hF0F0F0F0);
    issue("snpc",      3'b101, 32'h80000000, 32'h55,       1, 1, 1, 1, 32'h80000004);
    idle();
    check_hold("snpc_hold", 32'h80000004);

    // Async reset mid-stream: asserted between edges, outputs must clear at once.
    issue("pre_reset", 3'b000, 32'd10,       32'd20,       0, 0, 0, 0, 32'd30);
    idle();
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset", 32'd0, 1'b0);
    #1;
    reset = 1'b0;
    check_hold("hold_after_midreset", 32'd0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results never presented, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
